// File: rtl/secuenciador_instr.sv
// Instruction sequencer: plays a loaded program onto the datapath instruction bus,
// holding each word for CICLOS cycles, stopping early on a HALT opcode.
module secuenciador_instr #(
  parameter int PROF   = 16,
  parameter int CICLOS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cargar_en,
  input  logic [3:0]  cargar_dir,
  input  logic [18:0] cargar_dato,
  input  logic        iniciar,
  input  logic [4:0]  longitud,
  output logic [18:0] instruccion,
  output logic        instr_valida,
  output logic        ocupado,
  output logic        terminado,
  output logic [3:0]  pc,
  output logic [1:0]  estado_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

  localparam logic [4:0] PROF_L    = 5'(PROF);
  localparam logic [7:0] HOLD_LAST = 8'(CICLOS - 1);
  localparam logic [3:0] OP_HALT   = 4'hF;

  estado_t     state_q, state_d;
  logic [18:0] instr_q, instr_d;
  logic        valida_q, valida_d;
  logic [3:0]  pc_q, pc_d;
  logic [7:0]  hold_q, hold_d;
  logic [4:0]  len_q, len_d;
  logic        mem_we;
  logic [3:0]  pc_next;
  logic [18:0] word_next;
  logic [18:0] mem_q [PROF];

  assign pc_next   = pc_q + 4'd1;
  assign word_next = mem_q[pc_next];

  // instr_valida is a valid-only strobe (no ready): the datapath must consume
  // instruccion in every cycle where instr_valida is high; there is no backpressure.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valida_d = valida_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    len_d    = len_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        instr_d  = 19'd0;
        valida_d = 1'b0;
        if (iniciar) begin
          if (longitud == 5'd0) begin
            state_d = DONE;
          end else begin
            len_d  = (longitud > PROF_L) ? PROF_L : longitud;
            pc_d   = 4'd0;
            hold_d = 8'd0;
            if (mem_q[0][18:15] == OP_HALT) begin
              state_d = DONE;
            end else begin
              instr_d  = mem_q[0];
              valida_d = 1'b1;
              state_d  = RUN;
            end
          end
        end else if (cargar_en && !rst) begin
          mem_we = 1'b1;
        end
      end
      RUN: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = 8'd0;
          // A HALT word is never put on the bus; it ends the run like the last word.
          if (({1'b0, pc_q} == len_q - 5'd1) || (word_next[18:15] == OP_HALT)) begin
            state_d  = DONE;
            instr_d  = 19'd0;
            valida_d = 1'b0;
          end else begin
            pc_d    = pc_next;
            instr_d = word_next;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        instr_d  = 19'd0;
        valida_d = 1'b0;
        hold_d   = 8'd0;
      end
      default: begin
        state_d  = IDLE;
        instr_d  = 19'd0;
        valida_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= 19'd0;
      valida_q <= 1'b0;
      pc_q     <= 4'd0;
      hold_q   <= 8'd0;
      len_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      valida_q <= valida_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      len_q    <= len_d;
    end
  end

  // Program memory survives reset so a program can be replayed after an abort.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[cargar_dir] <= cargar_dato;
    end
  end

  assign instruccion  = instr_q;
  assign instr_valida = valida_q;
  assign ocupado      = (state_q == RUN);
  assign terminado    = (state_q == DONE);
  assign pc           = pc_q;
  assign estado_dbg   = state_q;

endmodule

// File: tb/tb_secuenciador_instr.sv
// Bench for secuenciador_instr: a per-cycle expected-output model built from the
// program contents, plus directed scenarios with hand-computed latencies and counts.
module tb_secuenciador_instr;

  localparam int PROF   = 16;
  localparam int CICLOS = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cargar_en;
  logic [3:0]  cargar_dir;
  logic [18:0] cargar_dato;
  logic        iniciar;
  logic [4:0]  longitud;
  logic [18:0] instruccion;
  logic        instr_valida;
  logic        ocupado;
  logic        terminado;
  logic [3:0]  pc;
  logic [1:0]  estado_dbg;

  secuenciador_instr #(.PROF(PROF), .CICLOS(CICLOS)) dut (
    .clk(clk), .rst(rst), .cargar_en(cargar_en), .cargar_dir(cargar_dir),
    .cargar_dato(cargar_dato), .iniciar(iniciar), .longitud(longitud),
    .instruccion(instruccion), .instr_valida(instr_valida), .ocupado(ocupado),
    .terminado(terminado), .pc(pc), .estado_dbg(estado_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 = idle, 1 = emitting a word, 2 = completion pulse
  typedef struct packed {
    logic [1:0]  kind;
    logic [18:0] word;
    logic [4:0]  idx;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        cur;
  logic [18:0] mdl_mem [PROF];
  logic        mdl_live = 1'b0;

  // Model: a start expands the program into the full per-cycle output timeline.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur      = '0;
      mdl_live = 1'b1;
    end else if (mdl_live) begin
      if (cur.kind == 2'd0) begin
        if (iniciar) begin
          int n;
          n = (int'(longitud) > PROF) ? PROF : int'(longitud);
          for (int i = 0; i < n; i++) begin
            if (mdl_mem[i][18:15] == 4'hF) break;
            for (int c = 0; c < CICLOS; c++) exp_q.push_back({2'd1, mdl_mem[i], 5'(i)});
          end
          exp_q.push_back({2'd2, 19'd0, 5'd0});
          cur = exp_q.pop_front();
        end else if (cargar_en) begin
          mdl_mem[cargar_dir] = cargar_dato;
        end
      end else if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
      end else begin
        cur = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_live) begin
      chk("instruccion", 32'(instruccion), 32'((cur.kind == 2'd1) ? cur.word : 19'd0));
      chk("instr_valida", 32'(instr_valida), 32'(cur.kind == 2'd1));
      chk("ocupado", 32'(ocupado), 32'(cur.kind == 2'd1));
      chk("terminado", 32'(terminado), 32'(cur.kind == 2'd2));
      if (cur.kind == 2'd1) chk("pc", 32'(pc), 32'(cur.idx[3:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [3:0] dir, input logic [18:0] dato);
    cargar_en   = 1'b1;
    cargar_dir  = dir;
    cargar_dato = dato;
    step();
    cargar_en = 1'b0;
  endtask

  // lat = edges from the start edge to the edge entering completion
  task automatic run_prog(input logic [4:0] len, output int lat, output int nvalid,
                          output int maxpc, output logic [18:0] first_w);
    iniciar  = 1'b1;
    longitud = len;
    step();
    iniciar = 1'b0;
    lat     = -1;
    nvalid  = 0;
    maxpc   = 0;
    first_w = 'x;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) first_w = instruccion;
      if (instr_valida) begin
        nvalid++;
        if (int'(pc) > maxpc) maxpc = int'(pc);
      end
      if (terminado) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("terminado_timeout", 32'hFFFF_FFFF, 32'd0);
    step();
  endtask

  localparam logic [18:0] W0 = 19'b0011_00100_00000_00001;
  localparam logic [18:0] W1 = 19'b0100_00101_00001_00010;
  localparam logic [18:0] W2 = 19'b0101_00110_00010_00011;
  localparam logic [18:0] W3 = 19'b0111_00000_00111_00100;
  localparam logic [18:0] W4 = 19'b0111_00000_01000_00101;
  localparam logic [18:0] W5 = 19'b0111_00000_01001_00110;

  // ---------------- directed scenarios ----------------
  initial begin
    int lat, nvalid, maxpc, pulses;
    logic [18:0] fw;
    logic [18:0] prog [6];
    prog = '{W0, W1, W2, W3, W4, W5};

    rst = 1'b1; cargar_en = 1'b0; cargar_dir = '0; cargar_dato = '0;
    iniciar = 1'b0; longitud = '0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_instruccion", 32'(instruccion), 32'd0);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);
    step();

    for (int i = 0; i < 6; i++) load(4'(i), prog[i]);
    for (int i = 6; i < PROF; i++) load(4'(i), {4'h1, 5'(i), 5'd1, 5'd2});

    // full six-word program
    run_prog(5'd6, lat, nvalid, maxpc, fw);
    chk("six_latency", 32'(lat), 32'd30);
    chk("six_valid_cycles", 32'(nvalid), 32'd30);
    chk("six_max_pc", 32'(maxpc), 32'd5);
    chk("six_first_word", 32'(fw), 32'(W0));

    // HALT in slot 2 stops after two words
    load(4'd2, 19'b1111_00000_00000_00000);
    run_prog(5'd6, lat, nvalid, maxpc, fw);
    chk("halt_latency", 32'(lat), 32'd10);
    chk("halt_valid_cycles", 32'(nvalid), 32'd10);
    chk("halt_max_pc", 32'(maxpc), 32'd1);
    load(4'd2, W2);

    // reset during the third instruction, with start and write also asserted
    iniciar = 1'b1; longitud = 5'd6;
    step();
    iniciar = 1'b0;
    repeat (11) step();
    @(negedge clk);
    chk("pre_reset_pc", 32'(pc), 32'd2);
    chk("pre_reset_word", 32'(instruccion), 32'(W2));
    step();
    rst = 1'b1; iniciar = 1'b1; cargar_en = 1'b1; cargar_dir = 4'd0; cargar_dato = 19'h12345;
    step();
    rst = 1'b0; iniciar = 1'b0; cargar_en = 1'b0;
    @(negedge clk);
    chk("post_reset_instruccion", 32'(instruccion), 32'd0);
    chk("post_reset_ocupado", 32'(ocupado), 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (terminado) pulses++;
    end
    chk("post_reset_no_pulse", 32'(pulses), 32'd0);
    step();
    run_prog(5'd6, lat, nvalid, maxpc, fw);
    chk("replay_first_word", 32'(fw), 32'(W0));
    chk("replay_latency", 32'(lat), 32'd30);

    // write during RUN is dropped; write together with start is dropped
    iniciar = 1'b1; longitud = 5'd3;
    step();
    iniciar = 1'b0;
    step();
    load(4'd0, 19'h12345);
    repeat (20) step();
    cargar_en = 1'b1; cargar_dir = 4'd0; cargar_dato = 19'h23456;
    run_prog(5'd2, lat, nvalid, maxpc, fw);
    cargar_en = 1'b0;
    chk("write_ignored_word", 32'(fw), 32'(W0));
    chk("two_latency", 32'(lat), 32'd10);

    // zero length
    run_prog(5'd0, lat, nvalid, maxpc, fw);
    chk("zero_latency", 32'(lat), 32'd0);
    chk("zero_valid_cycles", 32'(nvalid), 32'd0);

    // length beyond memory depth clamps to PROF
    run_prog(5'd20, lat, nvalid, maxpc, fw);
    chk("clamp_valid_cycles", 32'(nvalid), 32'd80);
    chk("clamp_max_pc", 32'(maxpc), 32'd15);
    chk("clamp_latency", 32'(lat), 32'd80);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/secuenciador_instr.md
SECUENCIADOR_INSTR -- requirements
Module: secuenciador_instr

Interface
REQ-001 Parameter PROF, default 16, program memory depth in 19-bit words.
REQ-002 Parameter CICLOS, default 5, clock cycles each instruction is held on the output; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cargar_en  input  1  program-memory write strobe.
REQ-006 cargar_dir  input  4  program-memory write address.
REQ-007 cargar_dato  input  19  instruction word to write: [18:15] opcode, [14:10] dest, [9:5] srcA, [4:0] srcB.
REQ-008 iniciar  input  1  start-execution request, sampled each cycle.
REQ-009 longitud  input  5  number of instructions to run, latched at start.
REQ-010 instruccion  output  19  registered instruction word driven to the datapath `instruccion` input.
REQ-011 instr_valida  output  1  high while instruccion carries a program word.
REQ-012 ocupado  output  1  high while in state RUN.
REQ-013 terminado  output  1  one-cycle pulse on completion.
REQ-014 pc  output  4  index of the word currently on instruccion.

Function
REQ-015 The block SHALL hold PROF x 19-bit program memory with a synchronous write: cargar_en=1 in IDLE writes cargar_dato to cargar_dir at the clock edge.
REQ-016 The block SHALL ignore writes in RUN and DONE, and when iniciar is also 1 in the same cycle.
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IDLE SHALL drive instruccion=19'b0 (opcode 0000, a datapath NOP), instr_valida=0, ocupado=0.
REQ-019 In IDLE, iniciar=1 with longitud!=0 SHALL cause the following at the same edge: latch len=min(longitud,PROF); pc<=0; hold counter<=0; instruccion<=mem[0]; instr_valida<=1; state<=RUN.
REQ-020 In IDLE, iniciar=1 with longitud==0 SHALL go to DONE without emitting any instruction.
REQ-021 If a word about to be emitted has opcode 4'b1111 (HALT), the block SHALL NOT emit it and SHALL go to DONE with instruccion=0 and instr_valida=0.
REQ-022 In RUN, each instruction SHALL remain stable for exactly CICLOS cycles; the hold counter increments every cycle.
REQ-023 When the hold counter equals CICLOS-1 and pc==len-1, the block SHALL go to DONE, clear instruccion to 0 and clear instr_valida.
REQ-024 When the hold counter equals CICLOS-1 and pc!=len-1, the block SHALL set pc<=pc+1, instruccion<=mem[pc+1] and hold counter<=0, subject to REQ-021.
REQ-025 iniciar in RUN or DONE SHALL be ignored.
REQ-026 DONE SHALL last exactly one cycle with terminado=1, then return to IDLE; terminado SHALL be 0 in all other states.
REQ-027 pc SHALL NOT wrap; because len<=PROF, the final index is always at most PROF-1.
REQ-028 Total RUN duration SHALL be len*CICLOS cycles when the program contains no HALT.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, instruccion=0, instr_valida=0, ocupado=0, terminado=0, pc=0 and hold counter=0, including mid-RUN.
REQ-030 Program memory contents SHALL NOT be cleared by reset.
REQ-031 rst SHALL take priority over iniciar and cargar_en.

Verification
REQ-032 Load mem[0..5] = 0011_00100_00000_00001, 0100_00101_00001_00010, 0101_00110_00010_00011, 0111_00000_00111_00100, 0111_00000_01000_00101, 0111_00000_01001_00110; start with longitud=6 -> each word on instruccion for 5 cycles in order; pc 0..5; terminado pulses once 30 cycles after start; instruccion returns to 0.
REQ-033 Set mem[2]=1111_00000_00000_00000 and start with longitud=6 -> words 0 and 1 are emitted for 5 cycles each; no HALT word appears; terminado pulses 10 cycles after start.
REQ-034 Assert rst for one cycle during the third instruction -> next cycle instruccion=0, ocupado=0 and no terminado pulse; a new start replays from mem[0] with program contents intact.
REQ-035 Drive cargar_en=1 with cargar_dir=0 during RUN, then start again -> original mem[0] is emitted.
REQ-036 Drive iniciar=1 with longitud=0 -> terminado pulses the next cycle and instr_valida never rises.
REQ-037 Drive longitud=20 with PROF=16 and no HALT words -> exactly 16 instructions are emitted; pc stops at 15 without wrapping.
